// File: rtl/hdmi_frame_rd_sched_pkg.sv
// Shared definitions for the HDMI frame read scheduler: FSM encoding,
// default display geometry and the burst-count helper.
package hdmi_pkg;

  localparam int unsigned H_ACTIVE_DEF  = 1024;
  localparam int unsigned V_ACTIVE_DEF  = 768;
  localparam int unsigned BURST_LEN_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CHECK,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic int unsigned total_bursts(input int unsigned h_active,
                                               input int unsigned v_active,
                                               input int unsigned burst_len);
    return (h_active * v_active) / burst_len;
  endfunction

endpackage

// File: rtl/hdmi_frame_rd_sched_frame_buf_sel.sv
// Ping-pong frame buffer select: a completed write frame arms a swap that
// is taken at the next ARM cycle of the reader.
module frame_buf_sel (
  input  logic sclk,
  input  logic rst_n,
  input  logic wr_frame_done,
  input  logic arm,
  output logic sel
);

  logic sel_q;
  logic ready;
  logic swap;

  assign swap = arm & ready;
  // Effective select already reflects a swap taken this ARM cycle.
  assign sel  = sel_q ^ swap;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
      ready <= 1'b0;
    end else if (swap) begin
      sel_q <= ~sel_q;
      ready <= wr_frame_done;
    end else if (wr_frame_done) begin
      ready <= 1'b1;
    end
  end

endmodule

// File: rtl/hdmi_frame_rd_sched.sv
// DDR read-burst scheduler feeding the HDMI line FIFO.
// Define FRAME_SWAP_EN to ping-pong between BASE_ADDR0 and BASE_ADDR1.
module hdmi_frame_rd_sched
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned ADDR_W     = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR0 = 28'h0000000,
  parameter logic [ADDR_W-1:0] BASE_ADDR1 = 28'h0100000
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              vga_start,
  input  logic [9:0]        fifo_wr_cnt,
  input  logic              fifo_empty,
  input  logic              rd_fifo_en,
  input  logic              wr_frame_done,
  output logic              rd_req,
  input  logic              rd_grant,
  input  logic              rd_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  output logic              fifo_clr,
  output logic              frame_busy,
  output logic              underflow
);

  localparam int unsigned TOTAL  = total_bursts(H_ACTIVE, V_ACTIVE, BURST_LEN);
  localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
  localparam logic [9:0]  THRESH = 10'(FIFO_DEPTH - BURST_LEN);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  burst_cnt;
  logic              restart_pend;
  logic              restart;
  logic              arm;
  logic              buf_sel;
  logic [ADDR_W-1:0] base;

  assign arm     = (state == ST_ARM);
  assign restart = restart_pend | vga_start;
  assign base    = buf_sel ? BASE_ADDR1 : BASE_ADDR0;
  assign rd_len  = 8'(BURST_LEN);

`ifdef FRAME_SWAP_EN
  frame_buf_sel u_frame_buf_sel (
    .sclk          (sclk),
    .rst_n         (rst_n),
    .wr_frame_done (wr_frame_done),
    .arm           (arm),
    .sel           (buf_sel)
  );
`else
  logic unused_wr_frame_done;
  assign unused_wr_frame_done = wr_frame_done;
  assign buf_sel = 1'b0;
`endif

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rd_req     = 1'b0;
    fifo_clr   = 1'b0;
    frame_busy = 1'b0;
    unique case (state)
      ST_IDLE: if (vga_start) state_nxt = ST_ARM;
      ST_ARM: begin
        fifo_clr   = 1'b1;
        frame_busy = 1'b1;
        state_nxt  = ST_CHECK;
      end
      ST_CHECK: begin
        frame_busy = 1'b1;
        if (vga_start)                            state_nxt = ST_ARM;
        else if (burst_cnt == CNT_W'(TOTAL))      state_nxt = ST_DONE;
        else if (fifo_wr_cnt <= THRESH)           state_nxt = ST_REQ;
      end
      ST_REQ: begin
        frame_busy = 1'b1;
        // A new frame start withdraws the request in the same cycle.
        if (vga_start)     state_nxt = ST_ARM;
        else begin
          rd_req = 1'b1;
          if (rd_grant)    state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        frame_busy = 1'b1;
        if (rd_done) state_nxt = restart ? ST_ARM : ST_CHECK;
      end
      ST_DONE: if (vga_start) state_nxt = ST_ARM;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr      <= '0;
      burst_cnt    <= '0;
      restart_pend <= 1'b0;
    end else if (arm) begin
      rd_addr      <= base;
      burst_cnt    <= '0;
      restart_pend <= 1'b0;
    end else if (state == ST_WAIT) begin
      // An in-flight burst always completes; a restart skips the advance.
      if (rd_done) begin
        if (restart) begin
          restart_pend <= 1'b0;
        end else begin
          rd_addr   <= rd_addr + ADDR_W'(BURST_LEN);
          burst_cnt <= burst_cnt + 1'b1;
        end
      end else if (vga_start) begin
        restart_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n)                       underflow <= 1'b0;
    else if (rd_fifo_en & fifo_empty) underflow <= 1'b1;
    else if (arm)                     underflow <= 1'b0;
  end

endmodule

// File: tb/tb_hdmi_frame_rd_sched.sv
// Directed self-checking bench for hdmi_frame_rd_sched (default geometry).
module tb_hdmi_frame_rd_sched;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        vga_start;
  logic [9:0]  fifo_wr_cnt;
  logic        fifo_empty;
  logic        rd_fifo_en;
  logic        wr_frame_done;
  logic        rd_req;
  logic        rd_grant;
  logic        rd_done;
  logic [27:0] rd_addr;
  logic [7:0]  rd_len;
  logic        fifo_clr;
  logic        frame_busy;
  logic        underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [27:0] BASE0 = 28'h0000000;
  localparam logic [27:0] BASE1 = 28'h0100000;
`ifdef FRAME_SWAP_EN
  localparam logic [27:0] EXP_SWAP1 = BASE1;
  localparam logic [27:0] EXP_SWAP2 = BASE1;
`else
  localparam logic [27:0] EXP_SWAP1 = BASE0;
  localparam logic [27:0] EXP_SWAP2 = BASE0;
`endif

  hdmi_frame_rd_sched #(
    .H_ACTIVE   (1024),
    .V_ACTIVE   (768),
    .BURST_LEN  (64),
    .FIFO_DEPTH (512),
    .ADDR_W     (28),
    .BASE_ADDR0 (BASE0),
    .BASE_ADDR1 (BASE1)
  ) dut (
    .sclk          (sclk),
    .rst_n         (rst_n),
    .vga_start     (vga_start),
    .fifo_wr_cnt   (fifo_wr_cnt),
    .fifo_empty    (fifo_empty),
    .rd_fifo_en    (rd_fifo_en),
    .wr_frame_done (wr_frame_done),
    .rd_req        (rd_req),
    .rd_grant      (rd_grant),
    .rd_done       (rd_done),
    .rd_addr       (rd_addr),
    .rd_len        (rd_len),
    .fifo_clr      (fifo_clr),
    .frame_busy    (frame_busy),
    .underflow     (underflow)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One burst with an 8-cycle read latency, entered from CHECK.
  task automatic slow_burst();
    tick();
    rd_grant = 1'b1; tick(); rd_grant = 1'b0;
    repeat (7) tick();
    rd_done = 1'b1; tick(); rd_done = 1'b0;
  endtask

  initial begin
    int unsigned bursts;
    int unsigned addr_bad;
    int unsigned extra;
    logic        timeout;
    logic [27:0] exp_addr;
    logic [27:0] last_addr;

    rst_n = 1'b0; vga_start = 1'b0; fifo_wr_cnt = '0; fifo_empty = 1'b0;
    rd_fifo_en = 1'b0; wr_frame_done = 1'b0; rd_grant = 1'b0; rd_done = 1'b0;
    repeat (2) tick();
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_rd_len", 32'(rd_len), 32'd64);
    chk("rst_fifo_clr", 32'(fifo_clr), 32'd0);
    chk("rst_frame_busy", 32'(frame_busy), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // First frame start: ARM, CHECK, REQ
    vga_start = 1'b1; tick(); vga_start = 1'b0;
    chk("arm_fifo_clr", 32'(fifo_clr), 32'd1);
    chk("arm_frame_busy", 32'(frame_busy), 32'd1);
    chk("arm_rd_req", 32'(rd_req), 32'd0);
    tick();
    chk("check_fifo_clr", 32'(fifo_clr), 32'd0);
    chk("check_rd_req", 32'(rd_req), 32'd0);
    tick();
    chk("req_2cyc", 32'(rd_req), 32'd1);
    chk("req_addr0", 32'(rd_addr), 32'(BASE0));
    rd_grant = 1'b1; tick(); rd_grant = 1'b0;
    chk("req_drop_after_grant", 32'(rd_req), 32'd0);

    // FIFO threshold: 449 blocks, 448 allows
    fifo_wr_cnt = 10'd449;
    repeat (7) tick();
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("addr_after_burst0", 32'(rd_addr), 32'd64);
    repeat (3) tick();
    chk("thresh_449_no_req", 32'(rd_req), 32'd0);
    fifo_wr_cnt = 10'd448;
    tick();
    chk("thresh_448_req", 32'(rd_req), 32'd1);
    repeat (2) tick();
    chk("req_held_no_grant", 32'(rd_req), 32'd1);
    rd_grant = 1'b1; tick(); rd_grant = 1'b0;
    chk("req_drop_burst1", 32'(rd_req), 32'd0);

    // Underflow is sticky
    rd_fifo_en = 1'b1; fifo_empty = 1'b1; tick(); rd_fifo_en = 1'b0; fifo_empty = 1'b0;
    chk("underflow_set", 32'(underflow), 32'd1);
    tick();
    chk("underflow_sticky", 32'(underflow), 32'd1);
    repeat (5) tick();
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    fifo_wr_cnt = '0;
    slow_burst();
    slow_burst();

    // Restart during WAIT of the fifth burst
    tick();
    chk("burst5_addr", 32'(rd_addr), 32'd256);
    rd_grant = 1'b1; tick(); rd_grant = 1'b0;
    repeat (2) tick();
    vga_start = 1'b1; tick(); vga_start = 1'b0;
    chk("pend_busy", 32'(frame_busy), 32'd1);
    chk("pend_no_req", 32'(rd_req), 32'd0);
    repeat (4) tick();
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("restart_arm", 32'(fifo_clr), 32'd1);
    chk("restart_no_incr", 32'(rd_addr), 32'd256);
    chk("underflow_in_arm", 32'(underflow), 32'd1);
    tick();
    chk("restart_addr_base", 32'(rd_addr), 32'(BASE0));
    chk("underflow_cleared", 32'(underflow), 32'd0);
    tick();
    chk("restart_req", 32'(rd_req), 32'd1);

    // Abort in REQ; stray grant outside REQ ignored
    vga_start = 1'b1; tick(); vga_start = 1'b0;
    chk("abort_req_low", 32'(rd_req), 32'd0);
    chk("abort_arm", 32'(fifo_clr), 32'd1);
    rd_grant = 1'b1; fifo_wr_cnt = 10'd500; tick(); rd_grant = 1'b0;
    chk("stray_grant_check", 32'(rd_req), 32'd0);
    rd_grant = 1'b1; tick(); rd_grant = 1'b0;
    chk("stray_grant_stay", 32'(rd_req), 32'd0);
    fifo_wr_cnt = '0;
    tick();
    chk("after_stray_req", 32'(rd_req), 32'd1);

    // Full frame with a fast arbiter
    bursts = 0; addr_bad = 0; timeout = 1'b1; exp_addr = BASE0; last_addr = '0;
    for (int c = 0; c < 40000; c++) begin
      if (rd_req) begin
        if (rd_addr !== exp_addr) addr_bad++;
        last_addr = rd_addr;
        exp_addr  = exp_addr + 28'd64;
        bursts++;
        rd_grant = 1'b1; tick(); rd_grant = 1'b0;
        rd_done  = 1'b1; tick(); rd_done  = 1'b0;
      end else if (!frame_busy) begin
        timeout = 1'b0;
        break;
      end else begin
        tick();
      end
    end
    chk("frame_timeout", 32'(timeout), 32'd0);
    chk("frame_bursts", bursts, 32'd12288);
    chk("frame_last_addr", 32'(last_addr), 32'd786368);
    chk("frame_addr_seq", addr_bad, 32'd0);
    chk("frame_busy_end", 32'(frame_busy), 32'd0);
    extra = 0;
    repeat (20) begin
      tick();
      if (rd_req) extra++;
    end
    chk("done_no_req", extra, 32'd0);

    // Underflow set in the ARM cycle wins over the clear
    vga_start = 1'b1; tick(); vga_start = 1'b0;
    rd_fifo_en = 1'b1; fifo_empty = 1'b1; tick(); rd_fifo_en = 1'b0; fifo_empty = 1'b0;
    chk("uf_beats_arm", 32'(underflow), 32'd1);

    // Buffer select behaviour
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    vga_start = 1'b1; tick(); vga_start = 1'b0;
    tick();
    chk("swap_first", 32'(rd_addr), 32'(EXP_SWAP1));
    tick();
    vga_start = 1'b1; tick(); vga_start = 1'b0;
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    chk("swap_hold", 32'(rd_addr), 32'(EXP_SWAP2));
    tick();
    vga_start = 1'b1; tick(); vga_start = 1'b0;
    tick();
    chk("swap_back", 32'(rd_addr), 32'(BASE0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
